rr_request_scheduler: RTL and testbench

- Upstream stage of the 8-to-3 encoder datapath.
- Latches 8 independent request pulses into a pending register and arbitrates among them round-robin.
- Presents one granted request at a time as a strict one-hot vector plus its 3-bit index, under a valid/ready handshake.
- The downstream encoder therefore only ever sees legal one-hot or all-zero input.

---
 rtl/rr_request_scheduler_pkg.sv | 19 +
 rtl/rr_request_scheduler_if.sv | 34 +++
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_request_scheduler.sv | 66 ++++++
 tb/tb_rr_request_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_request_scheduler_pkg.sv
// Shared sizing, reset constants and the grant record for the round-robin
// request scheduler that feeds the 8-to-3 encoder datapath.
package rr_request_scheduler_pkg;

    localparam int N     = 8;   // number of request lines
    localparam int IDX_W = 3;   // width of a line index; N == 2**IDX_W

    // The pointer names the most recently granted line, so resetting it to
    // the top line makes the very first search start at bit 0.
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N - 1);

    // One registered grant as presented downstream.
    typedef struct packed {
        logic             valid;
        logic [N-1:0]     onehot;
        logic [IDX_W-1:0] idx;
    } grant_t;

endpackage

// File: rtl/rr_request_scheduler_if.sv
// Request/grant bundle between the request sources, the scheduler and the
// downstream encoder. The scheduler is the master; the consumer is the slave.
interface rr_request_scheduler_if;
    import rr_request_scheduler_pkg::*;

    logic [N-1:0]     req_in;
    logic             grant_ready;
    logic             grant_valid;
    logic [N-1:0]     grant_onehot;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     pending;
    logic             overflow;

    modport master (
        input  req_in,
        input  grant_ready,
        output grant_valid,
        output grant_onehot,
        output grant_idx,
        output pending,
        output overflow
    );

    modport slave (
        output req_in,
        output grant_ready,
        input  grant_valid,
        input  grant_onehot,
        input  grant_idx,
        input  pending,
        input  overflow
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner selection: rotate the candidate vector so the line after
// ptr sits at bit 0, take the lowest set bit, then rotate the result back.
module rr_pick
    import rr_request_scheduler_pkg::*;
(
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner_onehot,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any
);

    logic [IDX_W-1:0] start;    // first line searched; wraps because N == 2**IDX_W
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] pri_idx;
    logic             found;

    assign start = ptr + IDX_W'(1);

    // Rotate, fixed-priority pick on the rotated vector, rotate the index back.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the loop leaves a value unassigned and infers a latch.
        dbl           = {cand, cand};
        rot           = dbl[start +: N];
        pri_idx       = '0;
        found         = 1'b0;
        winner_onehot = '0;
        winner_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found   = 1'b1;
                pri_idx = IDX_W'(i);
            end
        end
        if (found) begin
            winner_idx    = pri_idx + start;
            winner_onehot = N'(1) << winner_idx;
        end
        any = found;
    end

endmodule

// File: rtl/rr_request_scheduler.sv
// Latches request pulses into a pending vector and hands them out one at a
// time, round-robin, as a one-hot grant plus index under valid/ready.
module rr_request_scheduler
    import rr_request_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rr_request_scheduler_if.master bus
);

    logic [N-1:0]     pending_q;
    logic [IDX_W-1:0] ptr_q;
    logic             overflow_q;
    grant_t           grant_q;

    logic             accept;
    logic [N-1:0]     clear;
    logic [N-1:0]     cand;
    logic [N-1:0]     win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

    // A granted line leaves the candidate set in the same cycle it is taken.
    assign accept = grant_q.valid & bus.grant_ready;
    assign clear  = accept ? grant_q.onehot : '0;
    assign cand   = pending_q & ~clear;

    rr_pick u_pick (
        .cand          (cand),
        .ptr           (ptr_q),
        .winner_onehot (win_onehot),
        .winner_idx    (win_idx),
        .any           (win_any)
    );

    // Pending capture, overflow detection, grant register and pointer update.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            pending_q  <= '0;
            ptr_q      <= PTR_RST;
            overflow_q <= 1'b0;
            grant_q    <= '0;
        end else begin
            // New requests only ever land in pending; they never bypass it.
            pending_q  <= cand | bus.req_in;
            // A request on the line being accepted re-arms it and is not a duplicate.
            overflow_q <= |(bus.req_in & cand);
            if (!grant_q.valid || accept) begin
                // rr_pick returns all zeros when nothing is eligible.
                grant_q <= '{valid: win_any, onehot: win_onehot, idx: win_idx};
            end
            if (accept) begin
                ptr_q <= grant_q.idx;
            end
        end
    end

    assign bus.pending      = pending_q;
    assign bus.overflow     = overflow_q;
    assign bus.grant_valid  = grant_q.valid;
    assign bus.grant_onehot = grant_q.onehot;
    assign bus.grant_idx    = grant_q.idx;

endmodule

// File: tb/tb_rr_request_scheduler.sv
// Directed bench for rr_request_scheduler: hand-computed expectations after
// every clock edge, sampled 1 time unit after the rising edge.
module tb_rr_request_scheduler;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    rr_request_scheduler_if bus ();

    rr_request_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check every output at once against the expected scheduler state.
    task automatic expect_out(input string tag, input logic v, input logic [7:0] oh,
                              input logic [2:0] idx, input logic [7:0] pend, input logic ovf);
        check({tag, ".valid"},    32'(bus.grant_valid),  32'(v));
        check({tag, ".onehot"},   32'(bus.grant_onehot), 32'(oh));
        check({tag, ".idx"},      32'(bus.grant_idx),    32'(idx));
        check({tag, ".pending"},  32'(bus.pending),      32'(pend));
        check({tag, ".overflow"}, 32'(bus.overflow),     32'(ovf));
    endtask

    // Advance one rising edge and move just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.req_in      = 8'h00;
        bus.grant_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_vec           = 0;
        n_bad           = 0;
        rst             = 1'b1;
        bus.req_in      = 8'hFF;
        bus.grant_ready = 1'b0;

        // Reset held two cycles with all requests high: everything discarded.
        step();
        expect_out("rst0", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
        step();
        expect_out("rst1", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
        rst        = 1'b0;
        bus.req_in = 8'h00;
        step();
        expect_out("rst_rel", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        // First request after reset goes to line 0.
        bus.req_in      = 8'h01;
        bus.grant_ready = 1'b1;
        step();
        expect_out("first_cap", 1'b0, 8'h00, 3'd0, 8'h01, 1'b0);
        bus.req_in = 8'h00;
        step();
        expect_out("first_gnt", 1'b1, 8'h01, 3'd0, 8'h01, 1'b0);
        step();
        expect_out("first_done", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        // Single request on line 2.
        do_reset();
        bus.grant_ready = 1'b1;
        bus.req_in      = 8'h04;
        step();
        expect_out("single_cap", 1'b0, 8'h00, 3'd0, 8'h04, 1'b0);
        bus.req_in = 8'h00;
        step();
        expect_out("single_gnt", 1'b1, 8'h04, 3'd2, 8'h04, 1'b0);
        step();
        expect_out("single_done", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        // Round-robin: 0 then 7; then 2 alone; then 0 then 2 with wrap from 3.
        do_reset();
        bus.grant_ready = 1'b1;
        bus.req_in      = 8'h81;
        step();
        bus.req_in = 8'h00;
        step();
        expect_out("rr_g0", 1'b1, 8'h01, 3'd0, 8'h81, 1'b0);
        step();
        expect_out("rr_g7", 1'b1, 8'h80, 3'd7, 8'h80, 1'b0);
        step();
        expect_out("rr_idle1", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
        bus.req_in = 8'h04;
        step();
        bus.req_in = 8'h00;
        step();
        expect_out("rr_g2", 1'b1, 8'h04, 3'd2, 8'h04, 1'b0);
        step();
        expect_out("rr_idle2", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
        bus.req_in = 8'h05;
        step();
        bus.req_in = 8'h00;
        step();
        expect_out("rr_wrap0", 1'b1, 8'h01, 3'd0, 8'h05, 1'b0);
        step();
        expect_out("rr_wrap2", 1'b1, 8'h04, 3'd2, 8'h04, 1'b0);
        step();
        expect_out("rr_idle3", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        // Back-to-back: all eight lines granted one per cycle in order.
        do_reset();
        bus.grant_ready = 1'b1;
        bus.req_in      = 8'hFF;
        step();
        bus.req_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pend_exp;
            pend_exp = 8'hFF << i;
            step();
            expect_out($sformatf("b2b%0d", i), 1'b1, 8'h01 << i, 3'(i), pend_exp, 1'b0);
        end
        step();
        expect_out("b2b_idle", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        // Backpressure: line 4 held for five cycles, then 4 and 5 back-to-back.
        do_reset();
        bus.req_in = 8'h30;
        step();
        bus.req_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out($sformatf("bp_hold%0d", i), 1'b1, 8'h10, 3'd4, 8'h30, 1'b0);
        end
        bus.grant_ready = 1'b1;
        step();
        expect_out("bp_g5", 1'b1, 8'h20, 3'd5, 8'h20, 1'b0);
        step();
        expect_out("bp_idle", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        // Overflow: duplicate on a stalled pending line pulses overflow once.
        do_reset();
        bus.req_in = 8'h08;
        step();
        expect_out("ov_cap", 1'b0, 8'h00, 3'd0, 8'h08, 1'b0);
        bus.req_in = 8'h00;
        step();
        expect_out("ov_w1", 1'b1, 8'h08, 3'd3, 8'h08, 1'b0);
        step();
        expect_out("ov_w2", 1'b1, 8'h08, 3'd3, 8'h08, 1'b0);
        bus.req_in = 8'h08;
        step();
        expect_out("ov_dup", 1'b1, 8'h08, 3'd3, 8'h08, 1'b1);
        bus.req_in = 8'h00;
        step();
        expect_out("ov_drop", 1'b1, 8'h08, 3'd3, 8'h08, 1'b0);
        bus.grant_ready = 1'b1;
        step();
        expect_out("ov_acc", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
        step();
        expect_out("ov_once", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        // Request on the line being accepted re-arms it without overflow.
        do_reset();
        bus.grant_ready = 1'b1;
        bus.req_in      = 8'h02;
        step();
        bus.req_in = 8'h00;
        step();
        expect_out("rearm_g", 1'b1, 8'h02, 3'd1, 8'h02, 1'b0);
        bus.req_in = 8'h02;
        step();
        expect_out("rearm_acc", 1'b0, 8'h00, 3'd0, 8'h02, 1'b0);
        bus.req_in = 8'h00;
        step();
        expect_out("rearm_g2", 1'b1, 8'h02, 3'd1, 8'h02, 1'b0);
        step();
        expect_out("rearm_idle", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        // Reset mid-grant drops the grant and all pending lines.
        do_reset();
        bus.req_in = 8'hC0;
        step();
        bus.req_in = 8'h00;
        step();
        expect_out("mid_g", 1'b1, 8'h40, 3'd6, 8'hC0, 1'b0);
        rst = 1'b1;
        step();
        expect_out("mid_rst", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
        rst = 1'b0;
        step();
        expect_out("mid_post1", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
        step();
        expect_out("mid_post2", 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
